fetch_sequencer: RTL
====================

# fetch_sequencer

Instruction-fetch stage of the pipelined synchronous-ROM microprocessor. It generates the program-memory address, tracks which address the synchronous ROM is currently returning, and captures the returned word into the instruction register for the decoder. The ROM data reaches this block through the combinational program-memory data path, which passes the value unchanged. Jumps squash the wrong-path word, and a downstream stall freezes the stage without losing or duplicating an instruction.

## Interface
- ADDR_W, 8, program-memory address width
- DATA_W, 8, instruction word width
- RESET_PC, 0, first address fetched after reset
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  downstream not ready; freeze the stage
- jump_req  in  1  decoder requests a taken jump this cycle
- jump_addr  in  ADDR_W  jump target
- pm_addr  out  ADDR_W  address to synchronous ROM; ROM samples it at each rising edge
- pm_data  in  DATA_W  ROM word for the address sampled at the previous edge
- ir  out  DATA_W  instruction register
- ir_pc  out  ADDR_W  address of the word in ir
- ir_valid  out  1  ir holds a valid, non-squashed instruction
- ir_count  out  16  number of valid loads into ir, wraps at 2^16

## Operation
- Internal registers:
  - pc_next: next sequential address to issue.
  - f1_pc / f1_valid: the address the ROM is currently returning, and whether it is valid.
  - ir, ir_pc, ir_valid, ir_count.
- pm_addr is combinational from registers and control inputs only. There is no path from pm_data.
  - stall=1: pm_addr = f1_pc. The ROM re-reads the same word, so pm_data stays consistent with f1_pc.
  - else if jump_req=1: pm_addr = jump_addr.
  - else: pm_addr = pc_next.
- Rising edge with stall=1: all registers hold. jump_req is ignored, so the decoder must keep it asserted until the stall clears.
- Rising edge with stall=0 and jump_req=1:
  - pc_next <= jump_addr+1; f1_pc <= jump_addr; f1_valid <= 1.
  - ir_valid <= 0, squashing the sequential word in F1.
  - ir, ir_pc and ir_count hold.
- Rising edge with stall=0 and jump_req=0:
  - pc_next <= pc_next+1; f1_pc <= pc_next; f1_valid <= 1.
  - ir <= pm_data; ir_pc <= f1_pc; ir_valid <= f1_valid.
  - ir_count increments when f1_valid=1.
- Address arithmetic is modulo 2^ADDR_W. 2^ADDR_W-1 is followed by 0 with no flag. jump_addr = 2^ADDR_W-1 gives pc_next = 0.
- ir_count is modulo 2^16 with silent wrap.
- Reset values, applied asynchronously while reset_n=0:
  - pc_next = RESET_PC, f1_pc = RESET_PC, f1_valid = 0.
  - ir = 0, ir_pc = 0, ir_valid = 0, ir_count = 0.
  - pm_addr therefore equals RESET_PC during reset, regardless of stall. If jump_req=1 it equals jump_addr, but jump_req is a don't-care during reset.
- Reset mid-operation discards any in-flight fetch. Fetching restarts from RESET_PC.

## Timing
- Latency is 2 rising edges from an address appearing on pm_addr to its word in ir with ir_valid=1.
- First edge after reset_n deasserts: the ROM samples RESET_PC and f1_valid rises. Second edge: ir = word(RESET_PC), ir_valid = 1.
- Steady-state throughput is one instruction per cycle while stall=0 and jump_req=0.
- Taken jump costs one bubble:
  - Edge k (jump_req=1): ir_valid = 0.
  - Edge k+1: ir = word(jump_addr), ir_pc = jump_addr, ir_valid = 1.
- Stall of N cycles:
  - ir, ir_pc and ir_valid are constant for N edges.
  - The first unstalled edge loads word(f1_pc), exactly the next sequential instruction.
- stall, jump_req and jump_addr must meet setup to clk. pm_addr settles within the same cycle, since it has a combinational path from these inputs.
- reset_n assertion clears state immediately, without waiting for an edge. Deassertion is expected to be synchronised to clk externally.

## Test plan
- Reset/sequential: ROM model word(a) = a^8'hA5, RESET_PC=0, stall=0.
  - pm_addr goes 0,1,2,… on successive cycles.
  - Second edge: ir=8'hA5, ir_pc=0, ir_valid=1. Third edge: ir=8'hA4, ir_pc=1.
  - ir_count = 2 after the third edge.
- Stall: assert stall for 3 cycles while ir_pc=4.
  - ir, ir_pc and ir_valid hold, and pm_addr=5 throughout.
  - After release, the next edge gives ir_pc=5, ir=8'hA0. No skip or duplicate; ir_count rises by exactly 1.
- Jump: jump_req=1, jump_addr=8'h40 in the cycle ir_pc=6.
  - pm_addr=8'h40 that cycle; next edge ir_valid=0.
  - Following edge: ir_pc=8'h40, ir=8'hE5. Address 7 never appears with ir_valid=1.
- Jump during stall: jump_req=1 and stall=1 together for 2 cycles.
  - State holds and pm_addr=f1_pc.
  - stall drops with jump_req still high: the jump is taken exactly once, as in the jump scenario.
- Wrap: RESET_PC=8'hFE.
  - ir_pc sequence FE, FF, 00, 01 with ir_valid continuously 1.
  - jump_addr=8'hFF: next fetch after FF is 00.
- Reset mid-run: drop reset_n between edges after 10 instructions.
  - ir, ir_pc, ir_valid and ir_count become 0 before the next edge, and pm_addr = RESET_PC.
  - After release, the reset/sequential scenario repeats exactly.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage bus bundling decoder control, ROM port and instruction register outputs
interface fetch_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              stall;
  logic              jump_req;
  logic [ADDR_W-1:0] jump_addr;
  logic [ADDR_W-1:0] pm_addr;
  logic [DATA_W-1:0] pm_data;
  logic [DATA_W-1:0] ir;
  logic [ADDR_W-1:0] ir_pc;
  logic              ir_valid;
  logic [15:0]       ir_count;
  modport master (
    input  stall, jump_req, jump_addr, pm_data,
    output pm_addr, ir, ir_pc, ir_valid, ir_count
  );
  modport slave (
    output stall, jump_req, jump_addr, pm_data,
    input  pm_addr, ir, ir_pc, ir_valid, ir_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: two-stage instruction fetch from a synchronous ROM into the instruction register,
// with jump squash and stall freeze.
module fetch_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0
) (
  input logic               clk,
  input logic               reset_n,
  fetch_sequencer_if.master bus
);
  logic [ADDR_W-1:0] pc_next_q, pc_next_d, f1_pc_q, f1_pc_d, ir_pc_q, ir_pc_d;
  logic              f1_valid_q, f1_valid_d, ir_valid_q, ir_valid_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [15:0]       ir_count_q, ir_count_d;
  // While stalled the ROM re-reads f1_pc so pm_data stays aligned with it
  assign bus.pm_addr  = bus.stall ? f1_pc_q : bus.jump_req ? bus.jump_addr : pc_next_q;
  assign bus.ir       = ir_q;
  assign bus.ir_pc    = ir_pc_q;
  assign bus.ir_valid = ir_valid_q;
  assign bus.ir_count = ir_count_q;
  always_comb begin
    pc_next_d  = pc_next_q;
    f1_pc_d    = f1_pc_q;
    f1_valid_d = f1_valid_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    ir_count_d = ir_count_q;
    if (!bus.stall && bus.jump_req) begin
      pc_next_d  = bus.jump_addr + 1'b1;
      f1_pc_d    = bus.jump_addr;
      f1_valid_d = 1'b1;
      ir_valid_d = 1'b0;
    end else if (!bus.stall) begin
      pc_next_d  = pc_next_q + 1'b1;
      f1_pc_d    = pc_next_q;
      f1_valid_d = 1'b1;
      ir_d       = bus.pm_data;
      ir_pc_d    = f1_pc_q;
      ir_valid_d = f1_valid_q;
      ir_count_d = ir_count_q + 16'(f1_valid_q);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_next_q  <= ADDR_W'(RESET_PC);
      f1_pc_q    <= ADDR_W'(RESET_PC);
      f1_valid_q <= 1'b0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      ir_count_q <= '0;
    end else begin
      pc_next_q  <= pc_next_d;
      f1_pc_q    <= f1_pc_d;
      f1_valid_q <= f1_valid_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      ir_count_q <= ir_count_d;
    end
  end
endmodule
